// File: rtl/packet_filter_pkg.sv
// Shared packet-switch types: filtered AXIS stream with destination tag,
// the ingress port count and the egress arbiter FSM states.
package packet_filter;

  localparam int NUM_INGRESS_PORTS = 4;

  typedef struct packed {
    logic        tvalid;
    logic [15:0] tdata;
    logic        tlast;
    logic [1:0]  tdest;
  } axis_d_source_t;

  typedef struct packed {
    logic tready;
  } axis_d_sink_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: one-hot of the first request at or
// after last_grant+1, wrapping modulo N; all zero when nothing requests.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  pick
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_grant) + k) % N);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/egress_arbiter.sv
// One crossbar column: round-robin selects whole packets addressed to
// PORT_ID from the ingress streams and forwards them through a registered AXIS master.
module egress_arbiter
  import packet_filter::*;
#(
  parameter int PORT_ID    = 0,
  parameter int NUM_INPUTS = NUM_INGRESS_PORTS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  axis_d_source_t [NUM_INPUTS-1:0]  in_source,
  output axis_d_sink_t   [NUM_INPUTS-1:0]  in_sink,
  output axis_d_source_t                   out_source,
  input  axis_d_sink_t                     out_sink,
  output logic [NUM_INPUTS-1:0]            grant,
  output logic [15:0]                      pkt_count
);

  localparam int         IW   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [1:0] DEST = 2'(PORT_ID);

  arb_state_t            state;
  logic [IW-1:0]         last_grant;
  logic [IW-1:0]         pick_idx;
  logic [NUM_INPUTS-1:0] req;
  logic [NUM_INPUTS-1:0] pick;
  logic                  sel_valid;
  logic                  sel_last;
  logic [15:0]           sel_data;
  logic                  out_full;
  logic                  out_last;
  logic [15:0]           out_data;
  logic [1:0]            out_dest;
  logic                  slot_free;
  logic                  accept;
  logic                  drain;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      req[i] = in_source[i].tvalid && (in_source[i].tdest == DEST);
    end
  end

  rr_picker #(.N(NUM_INPUTS), .IW(IW)) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

  // While locked, last_grant is the owner of the packet in flight.
  assign sel_valid = in_source[last_grant].tvalid;
  assign sel_last  = in_source[last_grant].tlast;
  assign sel_data  = in_source[last_grant].tdata;

  assign slot_free = !out_full || out_sink.tready;
  assign accept    = (state == ARB_LOCK) && slot_free && sel_valid;
  assign drain     = out_full && out_sink.tready;

  always_comb begin
    in_sink = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_sink[i].tready = (state == ARB_LOCK) && grant[i] && slot_free;
    end
  end

  assign out_source = '{tvalid: out_full, tdata: out_data, tlast: out_last, tdest: out_dest};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_INPUTS - 1);
    end else if (state == ARB_IDLE) begin
      if (|req) begin
        grant      <= pick;
        last_grant <= pick_idx;
        state      <= ARB_LOCK;
      end
    end else if (accept && sel_last) begin
      grant <= '0;
      state <= ARB_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_full <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_dest <= '0;
    end else if (accept) begin
      out_full <= 1'b1;
      out_data <= sel_data;
      out_last <= sel_last;
      out_dest <= DEST;
    end else if (drain) begin
      out_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count <= '0;
    end else if (drain && out_last) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_egress_arbiter.sv
// Randomized bench for egress_arbiter: per-input packet queues drive the column,
// a packet-level round-robin model predicts grant, readiness and the output register.
module tb_egress_arbiter;
  import packet_filter::*;

  localparam int PORT_ID = 1;
  localparam int N       = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  axis_d_source_t [N-1:0] in_source;
  axis_d_sink_t   [N-1:0] in_sink;
  axis_d_source_t        out_source;
  axis_d_sink_t          out_sink;
  logic [N-1:0]          grant;
  logic [15:0]           pkt_count;

  egress_arbiter #(.PORT_ID(PORT_ID), .NUM_INPUTS(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_source  (in_source),
    .in_sink    (in_sink),
    .out_source (out_source),
    .out_sink   (out_sink),
    .grant      (grant),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
    logic [1:0]  dest;
  } beat_t;

  beat_t q[N][$];
  bit    pres[N];
  int    hold[N];
  bit    gen_en;
  bit    nogap;
  int    otr_mode;
  logic  otr;
  int    gen_mine;

  // reference model state
  bit          m_lock;
  bit          m_full;
  bit          m_olast;
  int          m_owner;
  int          m_last;
  logic [15:0] m_odata;
  logic [1:0]  m_odest;
  int          m_cnt;
  int          m_acc;

  int checks;
  int errors;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock  = 0;
    m_full  = 0;
    m_olast = 0;
    m_owner = 0;
    m_last  = N - 1;
    m_odata = '0;
    m_odest = '0;
    m_cnt   = 0;
    gen_mine = 0;
  endtask

  task automatic push_pkt(input int i, input int len, input logic [15:0] base, input logic [1:0] dst);
    for (int b = 0; b < len; b++) begin
      q[i].push_back('{d: 16'(base * (b + 1)), l: (b == len - 1), dest: dst});
    end
    if (dst == 2'(PORT_ID)) gen_mine++;
  endtask

  // Evaluated on each rising edge from the stimulus the bench itself presented.
  task automatic model_step();
    bit    was_lock;
    bit    rdy;
    bit    acc;
    bit    drn;
    bit    found;
    int    idx;
    beat_t b;
    was_lock = m_lock;
    rdy = m_lock && (!m_full || otr);
    acc = rdy && pres[m_owner];
    drn = m_full && otr;
    if (drn && m_olast) m_cnt = (m_cnt + 1) % 65536;
    if (acc) begin
      b = q[m_owner].pop_front();
      pres[m_owner] = 0;
      hold[m_owner] = 0;
      m_full  = 1;
      m_odata = b.d;
      m_olast = b.l;
      m_odest = 2'(PORT_ID);
      m_acc++;
      if (b.l) m_lock = 0;
    end else if (drn) begin
      m_full = 0;
    end
    if (!was_lock) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && pres[idx] && q[idx][0].dest == 2'(PORT_ID)) begin
          found   = 1;
          m_lock  = 1;
          m_owner = idx;
          m_last  = idx;
        end
      end
    end
  endtask

  task automatic drive();
    logic [1:0] dst;
    for (int i = 0; i < N; i++) begin
      if (gen_en && q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
        dst = ($urandom_range(0, 3) == 0) ? 2'(PORT_ID + 1 + $urandom_range(0, 2)) : 2'(PORT_ID);
        push_pkt(i, $urandom_range(1, 4), 16'($urandom), dst);
      end
      // A packet for another column is withdrawn after a while, as if taken elsewhere.
      if (pres[i] && q[i][0].dest != 2'(PORT_ID)) begin
        hold[i]++;
        if (hold[i] > 6) begin
          while (q[i].size() > 0 && !q[i][0].l) q[i].delete(0);
          if (q[i].size() > 0) q[i].delete(0);
          pres[i] = 0;
          hold[i] = 0;
        end
      end
      if (!pres[i] && q[i].size() > 0) pres[i] = nogap || ($urandom_range(0, 2) != 0);
      if (pres[i]) begin
        in_source[i] = '{tvalid: 1'b1, tdata: q[i][0].d, tlast: q[i][0].l, tdest: q[i][0].dest};
      end else begin
        in_source[i] = '{tvalid: 1'b0, tdata: 16'($urandom), tlast: 1'($urandom), tdest: 2'($urandom)};
      end
    end
    case (otr_mode)
      0:       otr = 1'($urandom);
      1:       otr = ~otr;
      default: otr = 1'b1;
    endcase
    out_sink.tready = otr;
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    eg = m_lock ? (N'(1) << m_owner) : '0;
    check_eq("grant", 32'(grant), 32'(eg));
    check_eq("out_tvalid", 32'(out_source.tvalid), 32'(m_full));
    if (m_full) begin
      check_eq("out_tdata", 32'(out_source.tdata), 32'(m_odata));
      check_eq("out_tlast", 32'(out_source.tlast), 32'(m_olast));
      check_eq("out_tdest", 32'(out_source.tdest), 32'(m_odest));
    end
    check_eq("pkt_count", 32'(pkt_count), 32'(m_cnt));
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("tready%0d", i), 32'(in_sink[i].tready),
               32'(m_lock && (m_owner == i) && (!m_full || otr)));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    drive();
    #1 check_all();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      pres[i] = 0;
      hold[i] = 0;
      in_source[i] = '0;
    end
  endtask

  initial begin
    int acc0;
    bit reached;
    checks   = 0;
    errors   = 0;
    gen_en   = 0;
    nogap    = 1;
    otr_mode = 2;
    otr      = 1'b0;
    out_sink.tready = 1'b0;
    reset    = 1'b0;
    clear_sources();
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_tvalid", 32'(out_source.tvalid), 32'd0);
    check_eq("rst_tdata", 32'(out_source.tdata), 32'd0);
    check_eq("rst_tlast", 32'(out_source.tlast), 32'd0);
    check_eq("rst_tdest", 32'(out_source.tdest), 32'd0);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_pkt_count", 32'(pkt_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // single 3-beat packet from input 1
    push_pkt(1, 3, 16'h0011, 2'(PORT_ID));
    repeat (8) cycle();
    check_eq("single_pkt_count", 32'(pkt_count), 32'd1);

    // reset in the middle of a 4-beat packet on input 0
    push_pkt(0, 4, 16'h0101, 2'(PORT_ID));
    acc0 = m_acc;
    reached = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      cycle();
      if (m_acc - acc0 >= 2) reached = 1;
    end
    check_eq("midpkt_reached", 32'(reached), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("midrst_tvalid", 32'(out_source.tvalid), 32'd0);
    check_eq("midrst_grant", 32'(grant), 32'd0);
    check_eq("midrst_tready0", 32'(in_sink[0].tready), 32'd0);
    check_eq("midrst_pkt_count", 32'(pkt_count), 32'd0);
    clear_sources();
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // after reset, input 0 must win the first arbitration
    push_pkt(3, 1, 16'h0333, 2'(PORT_ID));
    push_pkt(2, 2, 16'h0222, 2'(PORT_ID));
    push_pkt(0, 2, 16'h0111, 2'(PORT_ID));
    cycle();
    cycle();
    check_eq("post_rst_first_grant", 32'(grant), 32'b0001);
    repeat (14) cycle();
    check_eq("post_rst_pkt_count", 32'(pkt_count), 32'd3);

    // randomized traffic under random, toggling and open backpressure
    gen_en = 1;
    nogap  = 0;
    for (int m = 0; m < 3; m++) begin
      otr_mode = m;
      repeat (800) cycle();
    end
    gen_en   = 0;
    otr_mode = 2;
    repeat (150) cycle();
    check_eq("total_pkts", 32'(pkt_count), 32'(gen_mine % 65536));
    check_eq("drained_tvalid", 32'(out_source.tvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
